up_arbiter: RTL and testbench

- Round-robin arbiter sharing one uP register-bank interface (up_rreq/up_rack, up_wreq/up_wack) between NUM_PORTS uP requesters, e.g. several up_apb3 bridges in front of one core register decoder.
- Read and write channels are arbitrated independently and may run concurrently.
- Each channel has a watchdog: a stuck downstream ack is turned into an ack with zero data plus a timeout pulse, so no bus master hangs.

---
 rtl/up_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_up_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_arbiter.sv
// Round-robin arbiter sharing one uP register-bank port between several
// requesters, with independent read/write channels and ack watchdogs.

module up_arbiter_chan #(
  parameter int N  = 2,
  parameter int PW = 16,
  parameter int TO = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N*PW-1:0] payload,
  input  logic          ack_in,
  output logic          busy,
  output logic [PW-1:0] m_payload,
  output logic [N-1:0]  ack_out,
  output logic          timeout
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TO > 0) ? $clog2(TO + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] grant;
  logic [IW-1:0] last;
  logic [IW-1:0] pick;
  logic          found;
  logic [CW-1:0] cnt;
  logic          expire;
  logic [PW-1:0] pl [N];

  // Split the flat per-port payload bus into one word per port.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      pl[i] = payload[i*PW +: PW];
    end
  end

  // Round robin: ports above the last grant first, then wrap to port 0.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && IW'(i) > last) begin
        found = 1'b1;
        pick  = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && IW'(i) <= last) begin
        found = 1'b1;
        pick  = IW'(i);
      end
    end
  end

  assign expire  = (TO != 0) && (cnt == CW'(TO - 1));
  assign busy    = (state == GRANT);
  assign timeout = busy && !ack_in && expire;

  // Ack goes only to the granted port, from downstream or the watchdog.
  always_comb begin
    ack_out = '0;
    if (busy && (ack_in || expire)) begin
      ack_out[grant] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: one RELEASE cycle lets the requester drop its req.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = GRANT;
      GRANT:   if (ack_in || expire) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner and its payload; run the saturating watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant     <= '0;
      last      <= IW'(N - 1);
      m_payload <= '0;
      cnt       <= '0;
    end else if (state == IDLE && found) begin
      grant     <= pick;
      last      <= pick;
      m_payload <= pl[pick];
      cnt       <= '0;
    end else if (state == GRANT && cnt != CW'(TO)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

module up_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int BUS_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                s_up_rreq,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0]  s_up_raddr,
  output logic [NUM_PORTS-1:0]                s_up_rack,
  output logic [BUS_WIDTH*8-1:0]              s_up_rdata,
  input  logic [NUM_PORTS-1:0]                s_up_wreq,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0]  s_up_waddr,
  input  logic [NUM_PORTS*BUS_WIDTH*8-1:0]    s_up_wdata,
  output logic [NUM_PORTS-1:0]                s_up_wack,
  output logic                                m_up_rreq,
  output logic [ADDRESS_WIDTH-1:0]            m_up_raddr,
  input  logic                                m_up_rack,
  input  logic [BUS_WIDTH*8-1:0]              m_up_rdata,
  output logic                                m_up_wreq,
  output logic [ADDRESS_WIDTH-1:0]            m_up_waddr,
  output logic [BUS_WIDTH*8-1:0]              m_up_wdata,
  input  logic                                m_up_wack,
  output logic                                rd_timeout,
  output logic                                wr_timeout
);

  localparam int AW  = ADDRESS_WIDTH;
  localparam int DW  = BUS_WIDTH * 8;
  localparam int WPW = AW + DW;

  logic [NUM_PORTS*WPW-1:0] wpay;
  logic [WPW-1:0]           wpay_m;
  logic [DW-1:0]            rdata_q;
  logic                     rack_any;

  up_arbiter_chan #(
    .N  (NUM_PORTS),
    .PW (AW),
    .TO (TIMEOUT_CYCLES)
  ) rd_chan (
    .clk       (clk),
    .rst       (rst),
    .req       (s_up_rreq),
    .payload   (s_up_raddr),
    .ack_in    (m_up_rack),
    .busy      (m_up_rreq),
    .m_payload (m_up_raddr),
    .ack_out   (s_up_rack),
    .timeout   (rd_timeout)
  );

  // Pack each write port's address and data into one payload word.
  always_comb begin
    wpay = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      wpay[i*WPW +: WPW] = {s_up_wdata[i*DW +: DW], s_up_waddr[i*AW +: AW]};
    end
  end

  up_arbiter_chan #(
    .N  (NUM_PORTS),
    .PW (WPW),
    .TO (TIMEOUT_CYCLES)
  ) wr_chan (
    .clk       (clk),
    .rst       (rst),
    .req       (s_up_wreq),
    .payload   (wpay),
    .ack_in    (m_up_wack),
    .busy      (m_up_wreq),
    .m_payload (wpay_m),
    .ack_out   (s_up_wack),
    .timeout   (wr_timeout)
  );

  assign m_up_waddr = wpay_m[AW-1:0];
  assign m_up_wdata = wpay_m[WPW-1:AW];
  assign rack_any   = |s_up_rack;

  // Hold the last returned read word; a watchdog expiry returns zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rack_any) begin
      rdata_q <= rd_timeout ? '0 : m_up_rdata;
    end
  end

  assign s_up_rdata = !rack_any  ? rdata_q :
                      rd_timeout ? '0 : m_up_rdata;

endmodule

// File: tb/tb_up_arbiter.sv
// Randomized scoreboard bench for up_arbiter: round-robin reference model,
// random downstream ack delays including watchdog expiry and reset abort.

module tb_up_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int BW = 4;
  localparam int DW = BW * 8;
  localparam int TO = 5;

  logic clk = 1'b0;
  logic rst;

  logic [N-1:0]    sreq   [2];
  logic [N*AW-1:0] saddr  [2];
  logic [N*DW-1:0] swdata;
  logic            mack   [2];
  logic [DW-1:0]   mrdata;
  logic [N-1:0]    req_snap [2];

  logic [N-1:0]  s_up_rack;
  logic [N-1:0]  s_up_wack;
  logic [DW-1:0] s_up_rdata;
  logic          m_up_rreq;
  logic          m_up_wreq;
  logic [AW-1:0] m_up_raddr;
  logic [AW-1:0] m_up_waddr;
  logic [DW-1:0] m_up_wdata;
  logic          rd_timeout;
  logic          wr_timeout;

  logic          mreq_v  [2];
  logic [AW-1:0] maddr_v [2];
  logic [N-1:0]  sack_v  [2];
  logic          to_v    [2];

  assign mreq_v[0]  = m_up_rreq;
  assign mreq_v[1]  = m_up_wreq;
  assign maddr_v[0] = m_up_raddr;
  assign maddr_v[1] = m_up_waddr;
  assign sack_v[0]  = s_up_rack;
  assign sack_v[1]  = s_up_wack;
  assign to_v[0]    = rd_timeout;
  assign to_v[1]    = wr_timeout;

  up_arbiter #(
    .NUM_PORTS      (N),
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (BW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_up_rreq  (sreq[0]),
    .s_up_raddr (saddr[0]),
    .s_up_rack  (s_up_rack),
    .s_up_rdata (s_up_rdata),
    .s_up_wreq  (sreq[1]),
    .s_up_waddr (saddr[1]),
    .s_up_wdata (swdata),
    .s_up_wack  (s_up_wack),
    .m_up_rreq  (m_up_rreq),
    .m_up_raddr (m_up_raddr),
    .m_up_rack  (mack[0]),
    .m_up_rdata (mrdata),
    .m_up_wreq  (m_up_wreq),
    .m_up_waddr (m_up_waddr),
    .m_up_wdata (m_up_wdata),
    .m_up_wack  (mack[1]),
    .rd_timeout (rd_timeout),
    .wr_timeout (wr_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic          to;
  } exp_t;

  exp_t q_r[$];
  exp_t q_w[$];

  int           total = 0;
  int           passed = 0;
  logic         run = 1'b0;
  int           force_d [2];
  logic [N-1:0] dir_req [2];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  function automatic void push(int ch, exp_t e);
    if (ch == 0) q_r.push_back(e);
    else q_w.push_back(e);
  endfunction

  function automatic void unpush(int ch);
    if (ch == 0 && q_r.size() > 0) q_r.delete(q_r.size() - 1);
    if (ch == 1 && q_w.size() > 0) q_w.delete(q_w.size() - 1);
  endfunction

  function automatic int qsize(int ch);
    return (ch == 0) ? q_r.size() : q_w.size();
  endfunction

  function automatic exp_t pop(int ch);
    if (ch == 0) return q_r.pop_front();
    return q_w.pop_front();
  endfunction

  // Reference arbitration: first requester cyclically after the last winner.
  function automatic int rr_pick(logic [N-1:0] rq, int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (rq[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    req_snap[0] <= sreq[0];
    req_snap[1] <= sreq[1];
  end

  // Per channel: downstream responder (after posedge) and requesters (negedge).
  task automatic chan(input int ch);
    bit            busy = 0;
    int            rel = 0;
    int            c = 0;
    int            d = 0;
    int            port = 0;
    int            last = N - 1;
    logic [DW-1:0] dat = '0;
    exp_t          e;
    sreq[ch]  = '0;
    saddr[ch] = '0;
    mack[ch]  = 1'b0;
    if (ch == 0) mrdata = '0;
    else swdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        if (busy) unpush(ch);
        busy = 0;
        rel = 0;
        last = N - 1;
        mack[ch] = 1'b0;
      end else begin
        if (busy) begin
          c++;
        end else if (rel > 0) begin
          chk("m_req_gap", mreq_v[ch], 0);
          rel--;
        end else if (mreq_v[ch]) begin
          port = rr_pick(req_snap[ch], last);
          chk("grant_valid", port >= 0, 1);
          if (port < 0) port = 0;
          last = port;
          chk("m_addr", maddr_v[ch], saddr[ch][port*AW +: AW]);
          if (ch == 1) chk("m_wdata", m_up_wdata, swdata[port*DW +: DW]);
          d = (force_d[ch] >= 0) ? force_d[ch] : $urandom_range(0, TO + 1);
          dat = $urandom;
          e.port = port;
          e.to = (d >= TO);
          e.data = (d >= TO) ? '0 : dat;
          push(ch, e);
          busy = 1;
          c = 0;
        end
        mack[ch] = busy && (c == d);
        if (ch == 0) mrdata = (busy && c == d) ? dat : DW'($urandom);
        if (busy) begin
          #1;
          chk("ack_timing", |sack_v[ch], (c == d) || (c == TO - 1));
          if (c == d || c == TO - 1) begin
            busy = 0;
            rel = 2;
          end
        end
      end
      @(negedge clk);
      for (int p = 0; p < N; p++) begin
        if (sreq[ch][p] && sack_v[ch][p]) begin
          sreq[ch][p] = 1'b0;
        end else if (!sreq[ch][p] &&
                     (dir_req[ch][p] || (run && $urandom_range(0, 2) == 0))) begin
          saddr[ch][p*AW +: AW] = dir_req[ch][p] ? AW'(16'h0100 + p * 4)
                                                 : AW'($urandom);
          if (ch == 1) swdata[p*DW +: DW] = $urandom;
          sreq[ch][p] = 1'b1;
        end
      end
    end
  endtask

  // Monitor: every ack is matched against the oldest expected response.
  task automatic monitor(input int ch);
    exp_t          e;
    logic [DW-1:0] last_rd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_rd = '0;
      end else if (sack_v[ch] != '0) begin
        if (qsize(ch) == 0) begin
          chk("ack_unexpected", sack_v[ch], 0);
        end else begin
          e = pop(ch);
          chk("ack_port", sack_v[ch], N'(1) << e.port);
          chk("timeout_flag", to_v[ch], e.to);
          if (ch == 0) begin
            chk("rdata", s_up_rdata, e.data);
            last_rd = s_up_rdata;
          end
        end
      end else begin
        chk("timeout_idle", to_v[ch], 0);
        if (ch == 0) chk("rdata_hold", s_up_rdata, last_rd);
      end
    end
  endtask

  initial chan(0);
  initial chan(1);
  initial monitor(0);
  initial monitor(1);

  initial begin
    rst = 1'b1;
    force_d[0] = -1;
    force_d[1] = -1;
    dir_req[0] = '0;
    dir_req[1] = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_rreq", m_up_rreq, 0);
    chk("rst_m_wreq", m_up_wreq, 0);
    chk("rst_m_raddr", m_up_raddr, 0);
    chk("rst_m_waddr", m_up_waddr, 0);
    chk("rst_m_wdata", m_up_wdata, 0);
    chk("rst_rack", s_up_rack, 0);
    chk("rst_wack", s_up_wack, 0);
    chk("rst_rdata", s_up_rdata, 0);
    chk("rst_rd_to", rd_timeout, 0);
    chk("rst_wr_to", wr_timeout, 0);
    rst = 1'b0;

    force_d[0] = 100;
    dir_req[0] = 3'b010;
    for (int i = 0; i < 20 && !m_up_rreq; i++) @(negedge clk);
    chk("abort_grant", m_up_rreq, 1);
    dir_req[0] = 3'b011;
    rst = 1'b1;
    #1;
    chk("abort_mreq", m_up_rreq, 0);
    chk("abort_rack", s_up_rack, 0);
    repeat (2) @(negedge clk);
    chk("abort_rack_hold", s_up_rack, 0);
    force_d[0] = 1;
    rst = 1'b0;
    for (int i = 0; i < 20 && s_up_rack == '0; i++) @(negedge clk);
    chk("post_reset_first", s_up_rack, 3'b001);
    dir_req[0] = '0;
    force_d[0] = -1;

    run = 1'b1;
    repeat (3000) @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sreq[0] == '0 && sreq[1] == '0 &&
          q_r.size() == 0 && q_w.size() == 0) break;
    end
    chk("drain_req", {sreq[0], sreq[1]}, 0);
    chk("drain_rq", q_r.size(), 0);
    chk("drain_wq", q_w.size(), 0);
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
